// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared constants, FSM state type and channel-to-select encoding for the mux scheduler.
package mux_sched_pkg;
  localparam int NUM_CH = 6;
  localparam int SEL_W = 5;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  function automatic logic [SEL_W-1:0] ch_to_sel(input logic [2:0] ch);
    return ch == 3'd0 ? '0 : SEL_W'(1) << (ch - 3'd1);
  endfunction
endpackage

// File: rtl/mux_channel_scheduler_rr_pick.sv
// rr_pick: combinational round-robin search for the first requester after last, wrapping.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        last,
  output logic              found,
  output logic [2:0]        idx
);
  logic [2:0] c;
  always_comb begin
    found = |req;
    idx = '0;
    c = '0;
    // scan farthest-first so the nearest requester after last wins
    for (int i = NUM_CH; i >= 1; i--) begin
      c = 3'((int'(last) + i) % NUM_CH);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/mux_channel_scheduler.sv
// mux_channel_scheduler: round-robin burst scheduler driving the select of a 6-to-1 priority mux.
module mux_channel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] req,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic              valid,
  output logic              burst_done
);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(BURST_LEN);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] last, last_n, cur, cur_n, idx;
  logic [SEL_W-1:0] sel_n;
  logic [NUM_CH-1:0] grant_n;
  logic valid_n, done_n, found;
  rr_pick u_pick (.req(req), .last(last), .found(found), .idx(idx));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= 3'd5;
      cur <= '0;
      sel <= '0;
      grant <= '0;
      valid <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
      cur <= cur_n;
      sel <= sel_n;
      grant <= grant_n;
      valid <= valid_n;
      burst_done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last;
    cur_n = cur;
    sel_n = sel;
    grant_n = grant;
    valid_n = valid;
    done_n = 1'b0;
    case (state)
      IDLE: if (enable && found) begin
        state_n = BURST;
        cur_n = idx;
        sel_n = ch_to_sel(idx);
        grant_n = NUM_CH'(1) << idx;
        valid_n = 1'b1;
        cnt_n = CNT_W'(1);
        done_n = LEN == CNT_W'(1);
      end
      BURST: if (cnt == LEN || !(|(req & grant))) begin
        // a request drop ends the burst early; its done pulse lands one cycle late
        state_n = GAP;
        valid_n = 1'b0;
        grant_n = '0;
        last_n = cur;
        done_n = cnt != LEN;
      end else begin
        cnt_n = cnt + CNT_W'(1);
        done_n = cnt_n == LEN;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mux_channel_scheduler.sv
// tb_mux_channel_scheduler: table vectors, directed corner sequences and random traffic against a reference model.
module tb_mux_channel_scheduler;
  localparam int BL = 4;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [5:0] req = '0;
  logic [4:0] sel;
  logic [5:0] grant;
  logic valid, burst_done;
  int vecs = 0, errs = 0;
  int m_last = 5, m_ch = 0, m_n = 0, m_cool = 0;
  bit m_valid = 0, m_done = 0;
  logic [4:0] m_sel = '0;
  typedef struct {
    logic [5:0] req;
    logic       en;
    logic [4:0] sel;
    logic [5:0] grant;
    logic       v;
    logic       d;
  } vec_t;
  vec_t tbl[12];

  mux_channel_scheduler #(.BURST_LEN(BL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .sel(sel), .grant(grant), .valid(valid), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] code(input int k);
    logic [4:0] t;
    t = '0;
    if (k > 0) t[k-1] = 1'b1;
    return t;
  endfunction

  function automatic logic [12:0] outv();
    return {sel, grant, valid, burst_done};
  endfunction

  function automatic logic [12:0] expv();
    return {m_sel, m_valid ? 6'(1 << m_ch) : 6'd0, m_valid, m_done};
  endfunction

  task automatic model_reset();
    m_last = 5; m_ch = 0; m_n = 0; m_cool = 0; m_valid = 0; m_done = 0; m_sel = '0;
  endtask

  task automatic model_step(input logic [5:0] r, input logic e);
    if (m_valid) begin
      if (m_n == BL || !r[m_ch]) begin
        m_done = (m_n != BL); m_valid = 0; m_last = m_ch; m_cool = 1;
      end else begin
        m_n++; m_done = (m_n == BL);
      end
    end else if (m_cool > 0) begin
      m_cool--; m_done = 0;
    end else begin
      m_done = 0;
      if (e && r != 0) begin
        for (int i = 6; i >= 1; i--) if (r[(m_last + i) % 6]) m_ch = (m_last + i) % 6;
        m_sel = code(m_ch); m_valid = 1; m_n = 1; m_done = (BL == 1);
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] r, input logic e, input string nm);
    req = r; enable = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    cmp(nm, 32'(outv()), 32'(expv()));
  endtask

  int vcnt, dcnt, prev_ch, cur_ch;
  bit prev_v;

  initial begin
    tbl[0]  = '{6'h3F, 1'b1, 5'b00000, 6'b000001, 1'b1, 1'b0};
    tbl[1]  = '{6'h3F, 1'b1, 5'b00000, 6'b000001, 1'b1, 1'b0};
    tbl[2]  = '{6'h3F, 1'b1, 5'b00000, 6'b000001, 1'b1, 1'b0};
    tbl[3]  = '{6'h3F, 1'b1, 5'b00000, 6'b000001, 1'b1, 1'b1};
    tbl[4]  = '{6'h3F, 1'b1, 5'b00000, 6'b000000, 1'b0, 1'b0};
    tbl[5]  = '{6'h3F, 1'b1, 5'b00000, 6'b000000, 1'b0, 1'b0};
    tbl[6]  = '{6'h3F, 1'b1, 5'b00001, 6'b000010, 1'b1, 1'b0};
    tbl[7]  = '{6'h3F, 1'b1, 5'b00001, 6'b000010, 1'b1, 1'b0};
    tbl[8]  = '{6'h3F, 1'b1, 5'b00001, 6'b000010, 1'b1, 1'b0};
    tbl[9]  = '{6'h3F, 1'b1, 5'b00001, 6'b000010, 1'b1, 1'b1};
    tbl[10] = '{6'h3F, 1'b1, 5'b00001, 6'b000000, 1'b0, 1'b0};
    tbl[11] = '{6'h3F, 1'b1, 5'b00001, 6'b000000, 1'b0, 1'b0};
    req = 6'h3F; enable = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      cmp("reset_outputs", 32'(outv()), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; enable = tbl[i].en;
      @(posedge clk);
      model_step(tbl[i].req, tbl[i].en);
      #1;
      cmp($sformatf("table_row%0d", i), 32'(outv()),
          32'({tbl[i].sel, tbl[i].grant, tbl[i].v, tbl[i].d}));
    end
    vcnt = 0;
    for (int i = 0; i < 18; i++) begin
      step(6'h08, 1'b1, "only_ch3");
      if (valid && sel == 5'b00100 && grant == 6'b001000) vcnt++;
    end
    cmp("ch3_valid_cycles", 32'(vcnt), 32'd12);
    vcnt = 0; dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(i < 2 ? 6'h04 : 6'h00, 1'b1, "ch2_pulse");
      if (valid && sel == 5'b00010) vcnt++;
      if (burst_done) dcnt++;
    end
    cmp("ch2_pulse_valid", 32'(vcnt), 32'd2);
    cmp("ch2_pulse_done", 32'(dcnt), 32'd1);
    prev_ch = -1; prev_v = 0;
    for (int i = 0; i < 36; i++) begin
      step(6'h22, 1'b1, "ch1_ch5");
      if (valid && !prev_v) begin
        cur_ch = sel == 5'b00001 ? 1 : sel == 5'b10000 ? 5 : 9;
        cmp("alt_channel_legal", 32'(cur_ch == 1 || cur_ch == 5), 32'd1);
        if (prev_ch >= 0) cmp("alt_no_repeat", 32'(cur_ch != prev_ch), 32'd1);
        prev_ch = cur_ch;
      end
      prev_v = valid;
    end
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(6'h3F, 1'b0, "enable_low");
      if (valid) vcnt++;
    end
    cmp("enable_low_no_grant", 32'(vcnt), 32'd0);
    step(6'h3F, 1'b1, "enable_start");
    vcnt = int'(valid);
    for (int i = 0; i < 11; i++) begin
      step(6'h3F, 1'b0, "enable_drop");
      if (valid) vcnt++;
    end
    cmp("enable_drop_burst_len", 32'(vcnt), 32'(BL));
    step(6'h10, 1'b1, "ch4_first");
    step(6'h10, 1'b1, "ch4_second");
    cmp("ch4_grant", 32'(grant), 32'h10);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset_drop", 32'(outv()), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    step(6'h3F, 1'b1, "post_reset");
    cmp("post_reset_ch0", 32'({grant, valid}), 32'({6'b000001, 1'b1}));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 6'($urandom);
      step(req, $urandom_range(0, 7) != 0, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
